dac_run_controller: RTL and testbench
=====================================

# dac_run_controller

Single-clock run/stop sequencer in the 50 MHz DAC domain, the responding end of the start/stop command crossing. It consumes the single-cycle start/stop command pulses delivered from the 125 MHz side, ramps the DAC amplitude up and down, and publishes the `dac_running`/`dac_stopped` status levels. It then waits for their round-trip feedback (status crossed to 125 MHz and back) before treating a transition as acknowledged.

## Interface
- `DAC_WIDTH`, default 16: width of the amplitude path.
- `AMP_STEP`, default 64: amplitude increment/decrement per cycle while ramping.
- `ACK_TIMEOUT`, default 1024: maximum cycles to wait for a feedback acknowledge.
- `clk_50` in 1: the only clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_cmd` in 1: single-cycle start pulse, already synchronized to `clk_50`.
- `stop_cmd` in 1: single-cycle stop pulse, already synchronized to `clk_50`.
- `amplitude_target` in DAC_WIDTH: unsigned run amplitude, sampled only when a start is accepted.
- `running_fb` in 1: `dac_running` after its round trip through 125 MHz.
- `stopped_fb` in 1: `dac_stopped` after its round trip through 125 MHz.
- `dac_running` out 1: level; run status toward the 125 MHz side.
- `dac_stopped` out 1: level; stop status toward the 125 MHz side.
- `dac_amplitude` out DAC_WIDTH: registered amplitude to the DAC datapath.
- `fifo_wr_enable` out 1: high only in RUNNING; gates acquisition FIFO writes.
- `ack_timeout_err` out 1: sticky; set when an acknowledge wait expires.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, RAMP_UP=1, RUN_ACK=2, RUNNING=3, RAMP_DOWN=4, STOP_ACK=5.
- Reset values:
  - state is IDLE.
  - `dac_stopped`=1.
  - `dac_running`, `fifo_wr_enable` and `ack_timeout_err` are 0.
  - `dac_amplitude` is 0.
  - The latched target and the timeout counter are 0.
- IDLE:
  - `start_cmd` alone latches `amplitude_target`, clears `dac_stopped` and `ack_timeout_err`, and goes to RAMP_UP.
  - If the latched target is 0, it goes directly to RUN_ACK instead.
  - `start_cmd` and `stop_cmd` in the same cycle: both are ignored.
  - `stop_cmd` alone is ignored.
- RAMP_UP:
  - Each cycle, `dac_amplitude` <= min(amp+AMP_STEP, target). The sum is computed at DAC_WIDTH+1 bits, so there is no wrap.
  - When the new value equals the target, go to RUN_ACK on the same edge.
  - `stop_cmd` (including one arriving together with `start_cmd`) goes to RAMP_DOWN from the current amplitude.
- RUN_ACK:
  - `dac_running`=1, registered on entry.
  - The timeout counter is cleared on entry and increments each cycle.
  - `running_fb`=1 goes to RUNNING.
  - Counter reaching ACK_TIMEOUT-1 sets `ack_timeout_err` and goes to RUNNING.
  - `stop_cmd` goes to RAMP_DOWN.
- RUNNING:
  - `fifo_wr_enable`=1.
  - `stop_cmd` goes to RAMP_DOWN.
  - `start_cmd` is ignored.
- RAMP_DOWN:
  - On entry, `dac_running`=0 and `fifo_wr_enable`=0.
  - Each cycle, amp <= (amp > AMP_STEP) ? amp-AMP_STEP : 0.
  - When the new value is 0, go to STOP_ACK on the same edge.
  - `start_cmd` is ignored.
- STOP_ACK:
  - `dac_stopped`=1, registered on entry.
  - The timeout counter is cleared on entry.
  - `stopped_fb`=1 together with `running_fb`=0 goes to IDLE.
  - Timeout sets `ack_timeout_err` and goes to IDLE.
  - `start_cmd` is ignored.
- `dac_stopped` remains 1 in IDLE until the next accepted start.
- `amplitude_target` changes outside acceptance have no effect.
- Asserting `reset_n` low mid-ramp or mid-acknowledge forces the reset values immediately, with no ramp-down.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- Start:
  - `start_cmd` high at edge N gives RAMP_UP and `dac_stopped`=0 after edge N.
  - The first amplitude step appears after edge N+1.
  - With target = k·AMP_STEP, amplitude reaches target and `dac_running`=1 after edge N+k.
- Run acknowledge: `running_fb` high at edge M gives `fifo_wr_enable`=1 after edge M.
- Stop:
  - `stop_cmd` at edge S from RUNNING gives `fifo_wr_enable`=0 and `dac_running`=0 after edge S.
  - Amplitude reaches 0 ceil(amp/AMP_STEP) edges later, with `dac_stopped`=1 on that same edge.
- Timeout: the acknowledge state is exited exactly ACK_TIMEOUT cycles after entry if no feedback arrives.
- Command pulses: each pulse is assumed to be one cycle wide. A pulse held for several cycles is evaluated every cycle under the rules above.

## Test plan
- Reset, then `start_cmd` with target=256 and AMP_STEP=64:
  - Amplitude reads 64, 128, 192, 256 on consecutive cycles.
  - `dac_running`=1 with amplitude 256.
  - `running_fb` is returned 4 cycles later; `fifo_wr_enable`=1 on the next cycle.
- From RUNNING at amplitude 200:
  - `stop_cmd` gives amplitude 136, 72, 8, 0.
  - `dac_stopped`=1 on the cycle amplitude hits 0.
  - `stopped_fb`=1 with `running_fb`=0 gives IDLE.
- `stop_cmd` two cycles into RAMP_UP (amplitude 128):
  - Ramps down to 0 and enters STOP_ACK.
  - `dac_running` is never asserted.
  - `fifo_wr_enable` is never asserted.
- No `running_fb` in RUN_ACK with ACK_TIMEOUT=16:
  - After exactly 16 cycles, `ack_timeout_err`=1 and state is RUNNING.
  - The next accepted `start_cmd` clears the error.
- Simultaneous `start_cmd` and `stop_cmd` in IDLE:
  - Nothing changes.
  - `start_cmd` during RUNNING or RAMP_DOWN is also ignored.
- `reset_n` pulsed low mid-RAMP_UP:
  - Asynchronously gives amplitude 0, `dac_stopped`=1, `dac_running`=0, state IDLE.

Source files
------------

// File: rtl/dac_run_controller.sv
// Run/stop sequencer for the 50 MHz DAC domain: ramps amplitude up/down on start/stop pulses and waits for status round-trip acknowledge.
// Latency: every output is registered; a command takes effect on the edge that samples it.
// Backpressure: none; commands arriving in states that do not accept them are dropped, and ack waits are bounded by ACK_TIMEOUT.
module dac_run_controller #(
  parameter int DAC_WIDTH   = 16,
  parameter int AMP_STEP    = 64,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 clk_50,
  input  logic                 reset_n,
  input  logic                 start_cmd,
  input  logic                 stop_cmd,
  input  logic [DAC_WIDTH-1:0] amplitude_target,
  input  logic                 running_fb,
  input  logic                 stopped_fb,
  output logic                 dac_running,
  output logic                 dac_stopped,
  output logic [DAC_WIDTH-1:0] dac_amplitude,
  output logic                 fifo_wr_enable,
  output logic                 ack_timeout_err,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN_ACK   = 3'd2,
    S_RUNNING   = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_STOP_ACK  = 3'd5
  } state_e;

  localparam int W1 = DAC_WIDTH + 1;
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [W1-1:0]        STEP_W = W1'(AMP_STEP);
  localparam logic [DAC_WIDTH-1:0] STEP_N = DAC_WIDTH'(AMP_STEP);
  localparam logic [CW-1:0]        CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [DAC_WIDTH-1:0] amp_q, amp_d;
  logic [DAC_WIDTH-1:0] target_q, target_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 running_q, running_d;
  logic                 stopped_q, stopped_d;
  logic                 fifo_q, fifo_d;
  logic                 err_q, err_d;

  logic [W1-1:0]        up_sum;
  logic [DAC_WIDTH-1:0] up_amp;
  logic [DAC_WIDTH-1:0] dn_amp;
  logic                 ack_expired;

  // Next ramp values; the up sum carries an extra bit so a step past full scale clamps to target instead of wrapping.
  always_comb begin
    up_sum      = {1'b0, amp_q} + STEP_W;
    up_amp      = (up_sum > {1'b0, target_q}) ? target_q : up_sum[DAC_WIDTH-1:0];
    dn_amp      = ({1'b0, amp_q} > STEP_W) ? (amp_q - STEP_N) : '0;
    ack_expired = (cnt_q == CNT_LAST);
  end

  // Sequencer next-state and registered-output updates.
  always_comb begin
    state_d   = state_q;
    amp_d     = amp_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    running_d = running_q;
    stopped_d = stopped_q;
    fifo_d    = fifo_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_cmd && !stop_cmd) begin
          target_d  = amplitude_target;
          stopped_d = 1'b0;
          err_d     = 1'b0;
          if (amplitude_target == '0) begin
            state_d   = S_RUN_ACK;
            running_d = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = S_RAMP_UP;
          end
        end
      end
      S_RAMP_UP: begin
        if (stop_cmd) begin
          state_d = S_RAMP_DOWN;
        end else begin
          amp_d = up_amp;
          if (up_amp == target_q) begin
            state_d   = S_RUN_ACK;
            running_d = 1'b1;
            cnt_d     = '0;
          end
        end
      end
      S_RUN_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (stop_cmd) begin
          state_d   = S_RAMP_DOWN;
          running_d = 1'b0;
        end else if (running_fb) begin
          state_d = S_RUNNING;
          fifo_d  = 1'b1;
        end else if (ack_expired) begin
          state_d = S_RUNNING;
          fifo_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_RUNNING: begin
        if (stop_cmd) begin
          state_d   = S_RAMP_DOWN;
          running_d = 1'b0;
          fifo_d    = 1'b0;
        end
      end
      S_RAMP_DOWN: begin
        amp_d = dn_amp;
        if (dn_amp == '0) begin
          state_d   = S_STOP_ACK;
          stopped_d = 1'b1;
          cnt_d     = '0;
        end
      end
      S_STOP_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (stopped_fb && !running_fb) begin
          state_d = S_IDLE;
        end else if (ack_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops straight to the stopped idle condition without ramping.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      amp_q     <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      stopped_q <= 1'b1;
      fifo_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      amp_q     <= amp_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      stopped_q <= stopped_d;
      fifo_q    <= fifo_d;
      err_q     <= err_d;
    end
  end

  assign dac_running     = running_q;
  assign dac_stopped     = stopped_q;
  assign dac_amplitude   = amp_q;
  assign fifo_wr_enable  = fifo_q;
  assign ack_timeout_err = err_q;
  assign state           = state_q;

endmodule

// File: tb/tb_dac_run_controller.sv
// Self-checking bench for dac_run_controller: vector table, directed corner sequences, then random commands against a reference model.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: not applicable; the bench drives command pulses freely.
module tb_dac_run_controller;

  localparam int W    = 16;
  localparam int STEP = 64;
  localparam int TO   = 16;

  localparam int P_IDLE = 0, P_UP = 1, P_RACK = 2, P_RUN = 3, P_DOWN = 4, P_SACK = 5;

  logic         clk_50 = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_cmd = 1'b0;
  logic         stop_cmd = 1'b0;
  logic [W-1:0] amplitude_target = '0;
  logic         running_fb = 1'b0;
  logic         stopped_fb = 1'b0;
  logic         dac_running;
  logic         dac_stopped;
  logic [W-1:0] dac_amplitude;
  logic         fifo_wr_enable;
  logic         ack_timeout_err;
  logic [2:0]   state;

  int checks = 0;
  int errors = 0;
  bit model_chk = 1'b0;

  // reference model: phase, amplitude, latched target, cycles spent waiting for ack
  int m_ph, m_amp, m_tgt, m_wait;
  bit m_run, m_stp, m_fifo, m_err;

  typedef struct {
    bit          st;
    bit          sp;
    logic [15:0] tgt;
    bit          rf;
    bit          sf;
    int          e_state;
    int          e_amp;
    bit          e_run;
    bit          e_stp;
    bit          e_fifo;
  } vec_t;

  vec_t vq[$];

  dac_run_controller #(
    .DAC_WIDTH  (W),
    .AMP_STEP   (STEP),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk_50          (clk_50),
    .reset_n         (reset_n),
    .start_cmd       (start_cmd),
    .stop_cmd        (stop_cmd),
    .amplitude_target(amplitude_target),
    .running_fb      (running_fb),
    .stopped_fb      (stopped_fb),
    .dac_running     (dac_running),
    .dac_stopped     (dac_stopped),
    .dac_amplitude   (dac_amplitude),
    .fifo_wr_enable  (fifo_wr_enable),
    .ack_timeout_err (ack_timeout_err),
    .state           (state)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_amp = 0; m_tgt = 0; m_wait = 0;
    m_run = 0; m_stp = 1; m_fifo = 0; m_err = 0;
  endtask

  // One clock edge of the specified behaviour, written with plain integer arithmetic.
  task automatic model_edge(input bit st, input bit sp, input int tgt, input bit rf, input bit sf);
    int nxt;
    case (m_ph)
      P_IDLE: if (st && !sp) begin
        m_tgt = tgt; m_stp = 0; m_err = 0;
        if (tgt == 0) begin m_ph = P_RACK; m_run = 1; m_wait = 0; end
        else m_ph = P_UP;
      end
      P_UP: if (sp) m_ph = P_DOWN;
      else begin
        nxt = m_amp + STEP;
        m_amp = (nxt < m_tgt) ? nxt : m_tgt;
        if (m_amp == m_tgt) begin m_ph = P_RACK; m_run = 1; m_wait = 0; end
      end
      P_RACK: if (sp) begin m_ph = P_DOWN; m_run = 0; end
      else if (rf) begin m_ph = P_RUN; m_fifo = 1; end
      else if (m_wait == TO - 1) begin m_ph = P_RUN; m_fifo = 1; m_err = 1; end
      else m_wait++;
      P_RUN: if (sp) begin m_ph = P_DOWN; m_run = 0; m_fifo = 0; end
      P_DOWN: begin
        m_amp = (m_amp > STEP) ? m_amp - STEP : 0;
        if (m_amp == 0) begin m_ph = P_SACK; m_stp = 1; m_wait = 0; end
      end
      P_SACK: if (sf && !rf) m_ph = P_IDLE;
      else if (m_wait == TO - 1) begin m_ph = P_IDLE; m_err = 1; end
      else m_wait++;
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic cmp_model();
    chk("model_state",   32'(state),           32'(m_ph));
    chk("model_amp",     32'(dac_amplitude),   32'(m_amp));
    chk("model_running", 32'(dac_running),     32'(m_run));
    chk("model_stopped", 32'(dac_stopped),     32'(m_stp));
    chk("model_fifo",    32'(fifo_wr_enable),  32'(m_fifo));
    chk("model_err",     32'(ack_timeout_err), 32'(m_err));
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model and sample outputs just after the edge.
  task automatic step(input bit st, input bit sp, input logic [15:0] tgt, input bit rf, input bit sf);
    @(negedge clk_50);
    start_cmd = st; stop_cmd = sp; amplitude_target = tgt; running_fb = rf; stopped_fb = sf;
    @(posedge clk_50);
    model_edge(st, sp, int'(tgt), rf, sf);
    #1;
    start_cmd = 0; stop_cmd = 0; running_fb = 0; stopped_fb = 0;
    if (model_chk) cmp_model();
  endtask

  function automatic vec_t mk(bit st, bit sp, logic [15:0] tgt, bit rf, bit sf,
                              int es, int ea, bit er, bit estp, bit ef);
    vec_t v;
    v.st = st; v.sp = sp; v.tgt = tgt; v.rf = rf; v.sf = sf;
    v.e_state = es; v.e_amp = ea; v.e_run = er; v.e_stp = estp; v.e_fifo = ef;
    return v;
  endfunction

  initial begin
    bit seen_run;
    bit seen_fifo;
    logic [15:0] rt;

    model_reset();
    reset_n = 0;
    repeat (3) @(posedge clk_50);
    #1;
    chk("reset_state",   32'(state),           32'd0);
    chk("reset_amp",     32'(dac_amplitude),   32'd0);
    chk("reset_running", 32'(dac_running),     32'd0);
    chk("reset_stopped", 32'(dac_stopped),     32'd1);
    chk("reset_fifo",    32'(fifo_wr_enable),  32'd0);
    chk("reset_err",     32'(ack_timeout_err), 32'd0);
    @(negedge clk_50);
    reset_n = 1;

    // st sp tgt rf sf | state amp run stopped fifo
    vq.push_back(mk(1,0,256,0,0, 1,  0,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 1, 64,0,0,0));
    vq.push_back(mk(0,0,999,0,0, 1,128,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 1,192,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 2,256,1,0,0));
    vq.push_back(mk(0,0,  0,0,0, 2,256,1,0,0));
    vq.push_back(mk(0,0,  0,0,0, 2,256,1,0,0));
    vq.push_back(mk(0,0,  0,0,0, 2,256,1,0,0));
    vq.push_back(mk(0,0,  0,1,0, 3,256,1,0,1));
    vq.push_back(mk(0,1,  0,0,0, 4,256,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 4,192,0,0,0));
    vq.push_back(mk(1,0, 50,0,0, 4,128,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 4, 64,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 5,  0,0,1,0));
    vq.push_back(mk(0,0,  0,0,1, 0,  0,0,1,0));
    vq.push_back(mk(1,1,300,0,0, 0,  0,0,1,0));
    vq.push_back(mk(0,1,  0,0,0, 0,  0,0,1,0));
    vq.push_back(mk(1,0,200,0,0, 1,  0,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 1, 64,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 1,128,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 1,192,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 2,200,1,0,0));
    vq.push_back(mk(0,0,  0,1,0, 3,200,1,0,1));
    vq.push_back(mk(1,0,500,0,0, 3,200,1,0,1));
    vq.push_back(mk(0,1,  0,0,0, 4,200,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 4,136,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 4, 72,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 4,  8,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 5,  0,0,1,0));
    vq.push_back(mk(0,0,  0,1,1, 5,  0,0,1,0));
    vq.push_back(mk(0,0,  0,0,1, 0,  0,0,1,0));
    vq.push_back(mk(1,0,  0,0,0, 2,  0,1,0,0));
    vq.push_back(mk(0,0,  0,1,0, 3,  0,1,0,1));
    vq.push_back(mk(0,1,  0,0,0, 4,  0,0,0,0));
    vq.push_back(mk(0,0,  0,0,0, 5,  0,0,1,0));
    vq.push_back(mk(0,0,  0,0,1, 0,  0,0,1,0));

    foreach (vq[i]) begin
      step(vq[i].st, vq[i].sp, vq[i].tgt, vq[i].rf, vq[i].sf);
      chk($sformatf("vec%0d_state", i),   32'(state),          32'(vq[i].e_state));
      chk($sformatf("vec%0d_amp", i),     32'(dac_amplitude),  32'(vq[i].e_amp));
      chk($sformatf("vec%0d_running", i), 32'(dac_running),    32'(vq[i].e_run));
      chk($sformatf("vec%0d_stopped", i), 32'(dac_stopped),    32'(vq[i].e_stp));
      chk($sformatf("vec%0d_fifo", i),    32'(fifo_wr_enable), 32'(vq[i].e_fifo));
    end

    // stop two cycles into the up-ramp: running and fifo enable must never rise
    seen_run = 0; seen_fifo = 0;
    step(1, 0, 16'd1000, 0, 0); seen_run |= dac_running; seen_fifo |= fifo_wr_enable;
    step(0, 0, 16'd0, 0, 0);    seen_run |= dac_running; seen_fifo |= fifo_wr_enable;
    step(0, 0, 16'd0, 0, 0);    seen_run |= dac_running; seen_fifo |= fifo_wr_enable;
    chk("early_stop_amp_before", 32'(dac_amplitude), 32'd128);
    step(0, 1, 16'd0, 0, 0);    seen_run |= dac_running; seen_fifo |= fifo_wr_enable;
    chk("early_stop_state", 32'(state), 32'd4);
    chk("early_stop_hold_amp", 32'(dac_amplitude), 32'd128);
    step(0, 0, 16'd0, 0, 0);    seen_run |= dac_running; seen_fifo |= fifo_wr_enable;
    chk("early_stop_amp64", 32'(dac_amplitude), 32'd64);
    step(0, 0, 16'd0, 0, 0);    seen_run |= dac_running; seen_fifo |= fifo_wr_enable;
    chk("early_stop_sack", 32'(state), 32'd5);
    chk("early_stop_stopped", 32'(dac_stopped), 32'd1);
    chk("early_stop_never_running", 32'(seen_run), 32'd0);
    chk("early_stop_never_fifo", 32'(seen_fifo), 32'd0);
    step(0, 0, 16'd0, 0, 1);
    chk("early_stop_idle", 32'(state), 32'd0);

    // run-ack timeout: exit exactly TO cycles after entry, error sticky until next start
    step(1, 0, 16'd64, 0, 0);
    step(0, 0, 16'd0, 0, 0);
    chk("to_entry_state", 32'(state), 32'd2);
    chk("to_entry_running", 32'(dac_running), 32'd1);
    for (int i = 1; i <= TO; i++) begin
      step(0, 0, 16'd0, 0, 0);
      if (i == TO - 1) begin
        chk("to_before_state", 32'(state), 32'd2);
        chk("to_before_err", 32'(ack_timeout_err), 32'd0);
      end
    end
    chk("to_exit_state", 32'(state), 32'd3);
    chk("to_exit_err", 32'(ack_timeout_err), 32'd1);
    chk("to_exit_fifo", 32'(fifo_wr_enable), 32'd1);
    step(0, 1, 16'd0, 0, 0);
    step(0, 0, 16'd0, 0, 0);
    step(0, 0, 16'd0, 0, 1);
    chk("to_sticky_idle", 32'(state), 32'd0);
    chk("to_sticky_err", 32'(ack_timeout_err), 32'd1);
    step(1, 0, 16'd64, 0, 0);
    chk("to_cleared_err", 32'(ack_timeout_err), 32'd0);

    // asynchronous reset in the middle of an up-ramp
    step(0, 0, 16'd0, 0, 0);
    step(0, 1, 16'd0, 0, 0);
    step(0, 0, 16'd0, 0, 0);
    step(0, 0, 16'd0, 0, 1);
    step(1, 0, 16'd1000, 0, 0);
    step(0, 0, 16'd0, 0, 0);
    step(0, 0, 16'd0, 0, 0);
    chk("arst_pre_amp", 32'(dac_amplitude), 32'd128);
    #3;
    reset_n = 0;
    #1;
    chk("arst_state",   32'(state),         32'd0);
    chk("arst_amp",     32'(dac_amplitude), 32'd0);
    chk("arst_stopped", 32'(dac_stopped),   32'd1);
    chk("arst_running", 32'(dac_running),   32'd0);
    model_reset();
    @(negedge clk_50);
    reset_n = 1;

    // random commands and feedback against the reference model
    model_chk = 1;
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 3))
        0: rt = 16'd0;
        1: rt = 16'($urandom_range(1, 16) * STEP);
        2: rt = 16'($urandom_range(1, 2000));
        default: rt = 16'(65535 - $urandom_range(0, 100));
      endcase
      step($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0, rt,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end
    model_chk = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
